// File: rtl/noise_channel.sv
// Noise channel (channel 4): a 15/7-bit LFSR clocked by a programmable
// divider, gated by a length counter and scaled by a volume envelope.
module noise_channel (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk256,
  input  logic       clk64,
  input  logic [5:0] length_data,
  input  logic [3:0] init_volume,
  input  logic       env_dir,
  input  logic [2:0] env_period,
  input  logic [3:0] shift_freq,
  input  logic       width_mode,
  input  logic [2:0] div_ratio,
  input  logic       trigger,
  input  logic       length_enable,
  output logic [3:0] noise
);

  typedef enum logic {
    CH_OFF = 1'b0,
    CH_ON  = 1'b1
  } ch_state_e;

  ch_state_e   state_q, state_d;

  logic        s256_q, p256_q;
  logic        s64_q,  p64_q;
  logic        trg_q,  trg_p_q;

  logic [14:0] lfsr_q, lfsr_d;
  logic [3:0]  vol_q,  vol_d;
  logic [2:0]  env_q,  env_d;
  logic [6:0]  len_q,  len_d;
  logic [21:0] div_q,  div_d;
  logic [3:0]  noise_q, noise_d;

  logic        tick256, tick64, trig_tick;
  logic [6:0]  base;
  logic [21:0] reload;
  logic        step_ok;
  logic        fb;
  logic [14:0] lfsr_step;
  logic        dac_on;

  assign tick256   = s256_q & ~p256_q;
  assign tick64    = s64_q  & ~p64_q;
  assign trig_tick = trg_q  & ~trg_p_q;

  // Base period 8 clks for r=0, else 16*r; full period is base << s.
  // 112 << 15 still fits in 22 bits, so no shift value can overflow.
  assign base    = (div_ratio == 3'd0) ? 7'd8 : {div_ratio, 4'b0000};
  assign reload  = (22'(base) << shift_freq) - 22'd1;
  // Shift values 14 and 15 stop the LFSR entirely.
  assign step_ok = (shift_freq[3:1] != 3'b111);

  assign fb = lfsr_q[0] ^ lfsr_q[1];
  always_comb begin
    lfsr_step = {fb, lfsr_q[14:1]};
    if (width_mode) lfsr_step[6] = fb;
  end

  // A zero starting volume that can only fall means the DAC is off.
  assign dac_on = (init_volume != 4'd0) | env_dir;

  // Timebase and trigger synchronisers plus their previous-value flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s256_q  <= 1'b0;
      p256_q  <= 1'b0;
      s64_q   <= 1'b0;
      p64_q   <= 1'b0;
      trg_q   <= 1'b0;
      trg_p_q <= 1'b0;
    end else begin
      s256_q  <= clk256;
      p256_q  <= s256_q;
      s64_q   <= clk64;
      p64_q   <= s64_q;
      trg_q   <= trigger;
      trg_p_q <= trg_q;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CH_OFF;
      lfsr_q  <= '1;
      vol_q   <= '0;
      env_q   <= '0;
      len_q   <= '0;
      div_q   <= '0;
      noise_q <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      vol_q   <= vol_d;
      env_q   <= env_d;
      len_q   <= len_d;
      div_q   <= div_d;
      noise_q <= noise_d;
    end
  end

  // Next-state: trigger restarts everything and masks same-cycle events;
  // otherwise divider, length and envelope updates apply independently.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    vol_d   = vol_q;
    env_d   = env_q;
    len_d   = len_q;
    div_d   = div_q;

    if (trig_tick) begin
      state_d = dac_on ? CH_ON : CH_OFF;
      lfsr_d  = '1;
      vol_d   = init_volume;
      env_d   = env_period;
      len_d   = 7'd64 - {1'b0, length_data};
      div_d   = reload;
    end else begin
      if (div_q == '0) begin
        div_d = reload;
        if (step_ok) lfsr_d = lfsr_step;
      end else begin
        div_d = div_q - 22'd1;
      end

      if (tick256 && length_enable && (state_q == CH_ON) && (len_q != '0)) begin
        len_d = len_q - 7'd1;
        if (len_q == 7'd1) state_d = CH_OFF;
      end

      // A counter already at or below 1 reaches zero on this tick; this
      // also covers a period that was 0 at trigger time and changed later.
      if (tick64 && (env_period != 3'd0)) begin
        if (env_q <= 3'd1) begin
          env_d = env_period;
          if (env_dir) begin
            if (vol_q != 4'd15) vol_d = vol_q + 4'd1;
          end else begin
            if (vol_q != 4'd0) vol_d = vol_q - 4'd1;
          end
        end else begin
          env_d = env_q - 3'd1;
        end
      end
    end
  end

  // Output sample from the current state, registered one clk later.
  always_comb begin
    noise_d = '0;
    if ((state_q == CH_ON) && !lfsr_q[0]) noise_d = vol_q;
  end

  assign noise = noise_q;

endmodule

// File: tb/tb_noise_channel.sv
// Directed bench for noise_channel: table of configuration/action records
// with expected samples, plus hand sequences for divider timing, LFSR
// sequences and mid-play reset.
module tb_noise_channel;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clk256, clk64;
  logic [5:0] length_data;
  logic [3:0] init_volume;
  logic       env_dir;
  logic [2:0] env_period;
  logic [3:0] shift_freq;
  logic       width_mode;
  logic [2:0] div_ratio;
  logic       trigger;
  logic       length_enable;
  logic [3:0] noise;

  noise_channel dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clk256        (clk256),
    .clk64         (clk64),
    .length_data   (length_data),
    .init_volume   (init_volume),
    .env_dir       (env_dir),
    .env_period    (env_period),
    .shift_freq    (shift_freq),
    .width_mode    (width_mode),
    .div_ratio     (div_ratio),
    .trigger       (trigger),
    .length_enable (length_enable),
    .noise         (noise)
  );

  always #5 clk = ~clk;

  localparam int OP_TRIG = 0;
  localparam int OP_WAIT = 1;
  localparam int OP_T64  = 2;
  localparam int OP_T256 = 3;

  typedef struct {
    int         op;
    int         n;
    logic [5:0] len;
    logic [3:0] vol;
    logic       dir;
    logic [2:0] per;
    logic [3:0] s;
    logic       w;
    logic [2:0] r;
    logic       le;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input int op, input int n, input logic [5:0] len,
                     input logic [3:0] vol, input logic dir, input logic [2:0] per,
                     input logic [3:0] s, input logic w, input logic [2:0] r,
                     input logic le, input logic [3:0] exp);
    vec_t v;
    v.op = op; v.n = n; v.len = len; v.vol = vol; v.dir = dir; v.per = per;
    v.s = s; v.w = w; v.r = r; v.le = le; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: noise=%0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic cfg(input logic [5:0] len, input logic [3:0] vol, input logic dir,
                     input logic [2:0] per, input logic [3:0] s, input logic w,
                     input logic [2:0] r, input logic le);
    length_data = len; init_volume = vol; env_dir = dir; env_period = per;
    shift_freq = s; width_mode = w; div_ratio = r; length_enable = le;
  endtask

  // Returns half a clk after the edge where the channel state restarts.
  task automatic do_trigger();
    @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic tick64();
    clk64 = 1'b1;
    repeat (3) @(negedge clk);
    clk64 = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic tick256();
    clk256 = 1'b1;
    repeat (3) @(negedge clk);
    clk256 = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Independent reference for the LFSR sequence comparisons.
  function automatic logic [14:0] model_step(input logic [14:0] m, input logic w);
    logic x;
    logic [14:0] n;
    x = m[0] ^ m[1];
    n = {x, m[14:1]};
    if (w) n[6] = x;
    return n;
  endfunction

  task automatic lfsr_seq(input string nm, input logic w, input int steps);
    logic [14:0] m;
    cfg(6'd0, 4'd5, 1'b0, 3'd0, 4'd0, w, 3'd0, 1'b0);
    do_trigger();
    @(negedge clk);
    m = '1;
    check(nm, noise, 4'd0);
    for (int k = 1; k <= steps; k++) begin
      repeat (8) @(negedge clk);
      m = model_step(m, w);
      check(nm, noise, m[0] ? 4'd0 : 4'd5);
    end
  endtask

  initial begin
    rst_n = 1'b0; trigger = 1'b0; clk256 = 1'b0; clk64 = 1'b0;
    cfg(6'd17, 4'd11, 1'b1, 3'd5, 4'd2, 1'b1, 3'd6, 1'b1);

    // Reset state, and no output without a trigger after release.
    repeat (3) @(negedge clk);
    check("reset", noise, 4'd0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("idle_after_reset", noise, 4'd0);

    // Basic: LFSR 8-clk steps, envelope -1 every 3 ticks, length disabled.
    add(OP_TRIG, 0,   6'd63, 4'd7, 1'b0, 3'd3, 4'd0,  1'b0, 3'd0, 1'b0, 4'd0);
    add(OP_WAIT, 100, 6'd63, 4'd7, 1'b0, 3'd3, 4'd0,  1'b0, 3'd0, 1'b0, 4'd0);
    add(OP_WAIT, 30,  6'd63, 4'd7, 1'b0, 3'd3, 4'd0,  1'b0, 3'd0, 1'b0, 4'd7);
    add(OP_WAIT, 10,  6'd63, 4'd7, 1'b0, 3'd3, 4'd14, 1'b0, 3'd0, 1'b0, 4'd7);
    add(OP_T64,  2,   6'd63, 4'd7, 1'b0, 3'd3, 4'd14, 1'b0, 3'd0, 1'b0, 4'd7);
    add(OP_T64,  1,   6'd63, 4'd7, 1'b0, 3'd3, 4'd14, 1'b0, 3'd0, 1'b0, 4'd6);
    add(OP_T256, 3,   6'd63, 4'd7, 1'b0, 3'd3, 4'd14, 1'b0, 3'd0, 1'b0, 4'd6);
    add(OP_T64,  3,   6'd63, 4'd7, 1'b0, 3'd3, 4'd14, 1'b0, 3'd0, 1'b0, 4'd5);
    add(OP_T64,  3,   6'd63, 4'd7, 1'b0, 3'd3, 4'd14, 1'b0, 3'd0, 1'b0, 4'd4);
    add(OP_T64,  9,   6'd63, 4'd7, 1'b0, 3'd3, 4'd14, 1'b0, 3'd0, 1'b0, 4'd1);
    add(OP_T64,  3,   6'd63, 4'd7, 1'b0, 3'd3, 4'd14, 1'b0, 3'd0, 1'b0, 4'd0);
    add(OP_T64,  6,   6'd63, 4'd7, 1'b0, 3'd3, 4'd14, 1'b0, 3'd0, 1'b0, 4'd0);
    // Length stop: L=60 gives exactly 4 length ticks.
    add(OP_TRIG, 0,   6'd60, 4'd15, 1'b0, 3'd0, 4'd0,  1'b0, 3'd0, 1'b1, 4'd0);
    add(OP_WAIT, 130, 6'd60, 4'd15, 1'b0, 3'd0, 4'd0,  1'b0, 3'd0, 1'b1, 4'd15);
    add(OP_WAIT, 10,  6'd60, 4'd15, 1'b0, 3'd0, 4'd14, 1'b0, 3'd0, 1'b1, 4'd15);
    add(OP_T256, 3,   6'd60, 4'd15, 1'b0, 3'd0, 4'd14, 1'b0, 3'd0, 1'b1, 4'd15);
    add(OP_T256, 1,   6'd60, 4'd15, 1'b0, 3'd0, 4'd14, 1'b0, 3'd0, 1'b1, 4'd0);
    add(OP_WAIT, 50,  6'd60, 4'd15, 1'b0, 3'd0, 4'd14, 1'b0, 3'd0, 1'b1, 4'd0);
    // Saturation at 15 with increasing envelope.
    add(OP_TRIG, 0,   6'd0, 4'd14, 1'b1, 3'd1, 4'd0,  1'b0, 3'd0, 1'b0, 4'd0);
    add(OP_WAIT, 130, 6'd0, 4'd14, 1'b1, 3'd1, 4'd0,  1'b0, 3'd0, 1'b0, 4'd14);
    add(OP_WAIT, 10,  6'd0, 4'd14, 1'b1, 3'd1, 4'd14, 1'b0, 3'd0, 1'b0, 4'd14);
    add(OP_T64,  1,   6'd0, 4'd14, 1'b1, 3'd1, 4'd14, 1'b0, 3'd0, 1'b0, 4'd15);
    add(OP_T64,  3,   6'd0, 4'd14, 1'b1, 3'd1, 4'd14, 1'b0, 3'd0, 1'b0, 4'd15);
    // Retrigger while playing: LFSR back to 7FFF, new volume.
    add(OP_TRIG, 0,   6'd0, 4'd9, 1'b0, 3'd0, 4'd0, 1'b0, 3'd0, 1'b0, 4'd0);
    add(OP_WAIT, 130, 6'd0, 4'd9, 1'b0, 3'd0, 4'd0, 1'b0, 3'd0, 1'b0, 4'd9);
    // DAC off, then volume 0 with increasing envelope (DAC on).
    add(OP_TRIG, 0,   6'd0, 4'd0, 1'b0, 3'd0, 4'd0,  1'b0, 3'd0, 1'b0, 4'd0);
    add(OP_WAIT, 130, 6'd0, 4'd0, 1'b0, 3'd0, 4'd0,  1'b0, 3'd0, 1'b0, 4'd0);
    add(OP_TRIG, 0,   6'd0, 4'd0, 1'b1, 3'd1, 4'd0,  1'b0, 3'd0, 1'b0, 4'd0);
    add(OP_WAIT, 130, 6'd0, 4'd0, 1'b1, 3'd1, 4'd0,  1'b0, 3'd0, 1'b0, 4'd0);
    add(OP_WAIT, 10,  6'd0, 4'd0, 1'b1, 3'd1, 4'd14, 1'b0, 3'd0, 1'b0, 4'd0);
    add(OP_T64,  1,   6'd0, 4'd0, 1'b1, 3'd1, 4'd14, 1'b0, 3'd0, 1'b0, 4'd1);
    // r=1, s=14: LFSR frozen at 7FFF, output stays 0.
    add(OP_TRIG, 0,    6'd0, 4'd6, 1'b0, 3'd0, 4'd14, 1'b0, 3'd1, 1'b0, 4'd0);
    add(OP_WAIT, 2000, 6'd0, 4'd6, 1'b0, 3'd0, 4'd14, 1'b0, 3'd1, 1'b0, 4'd0);

    foreach (tbl[i]) begin
      cfg(tbl[i].len, tbl[i].vol, tbl[i].dir, tbl[i].per,
          tbl[i].s, tbl[i].w, tbl[i].r, tbl[i].le);
      case (tbl[i].op)
        OP_TRIG: do_trigger();
        OP_WAIT: repeat (tbl[i].n) @(negedge clk);
        OP_T64:  repeat (tbl[i].n) tick64();
        default: repeat (tbl[i].n) tick256();
      endcase
      repeat (2) @(negedge clk);
      check($sformatf("vec%0d", i), noise, tbl[i].exp);
    end

    // r=2, s=3: 256-clk steps; the 15th step (first nonzero output) lands at 3840.
    cfg(6'd0, 4'd8, 1'b0, 3'd0, 4'd3, 1'b0, 3'd2, 1'b0);
    do_trigger();
    repeat (3830) @(negedge clk);
    check("div_r2s3_before", noise, 4'd0);
    repeat (20) @(negedge clk);
    check("div_r2s3_after", noise, 4'd8);

    lfsr_seq("lfsr7", 1'b1, 260);
    lfsr_seq("lfsr15", 1'b0, 60);

    // Reset in the middle of play clears output immediately.
    cfg(6'd0, 4'd10, 1'b0, 3'd0, 4'd0, 1'b0, 3'd0, 1'b0);
    do_trigger();
    repeat (134) @(negedge clk);
    shift_freq = 4'd14;
    repeat (10) @(negedge clk);
    check("play_before_reset", noise, 4'd10);
    rst_n = 1'b0;
    #1;
    check("async_reset", noise, 4'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("after_midplay_reset", noise, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/noise_channel.md
Name: noise_channel

Overview:
- Game Boy style noise channel (channel 4): a 15-bit LFSR, clocked by a programmable divider, produces a pseudo-random bit.
- A volume envelope (64 Hz) and a length counter (256 Hz) gate and scale that bit into a 4-bit sample.
- The block sits between the register/timer logic and the mixer/DAC. Its output goes straight to the left/right DAC inputs.

Parameters:
- none (divider constants fixed; clk nominal 4.194304 MHz)

Ports:
- clk  in  1  system clock (4.194304 MHz)
- rst_n  in  1  asynchronous active-low reset
- clk256  in  1  256 Hz timebase level from fixed timer; rising edge sampled in clk domain = one length tick
- clk64  in  1  64 Hz timebase level; rising edge sampled in clk domain = one envelope tick
- length_data  in  6  length load value L; channel plays 64-L length ticks
- init_volume  in  4  envelope starting volume
- env_dir  in  1  1 = increase, 0 = decrease
- env_period  in  3  envelope ticks per volume step; 0 = envelope frozen
- shift_freq  in  4  divider shift s
- width_mode  in  1  0 = 15-bit LFSR, 1 = 7-bit LFSR
- div_ratio  in  3  divider code r
- trigger  in  1  restart; level sampled on clk, rising edge detected; hold ≥1 clk
- length_enable  in  1  1 = length counter may stop channel
- noise  out  4  sample output

Behaviour:
- All state registers clear asynchronously when rst_n=0:
  - enabled=0, lfsr=15'h7FFF, volume=0, counters=0, edge-detect flops=0.
  - noise=0 during and after reset until a trigger.
- Timebase edges: clk256/clk64/trigger are registered once each; a tick is prev=0 & cur=1. Each tick is a single-clk event.
- Trigger (rising edge, one clk later):
  - enabled=1; lfsr=15'h7FFF; volume=init_volume.
  - env_counter=env_period; length_counter=64-length_data (7-bit, value 1..64).
  - divider counter reloaded.
  - If init_volume=0 and env_dir=0 (DAC off): enabled stays 0.
- Divider:
  - Base period B = 8 clks for r=0, else 16*r clks. Period = B << s.
  - Counter decrements each clk. On reaching 0: reload and step the LFSR.
  - s=14 or 15: LFSR never steps.
- LFSR step:
  - x = lfsr[0] ^ lfsr[1]; lfsr = lfsr >> 1; lfsr[14] = x.
  - If width_mode=1, also lfsr[6] = x.
- Length:
  - On a 256 Hz tick with length_enable=1, enabled=1 and length_counter>0: decrement.
  - Reaching 0 sets enabled=0.
  - length_enable=0: counter holds and the channel plays indefinitely.
- Envelope:
  - Runs on a 64 Hz tick with env_period≠0. env_counter decrements; on reaching 0 it reloads env_period.
  - On reload, volume steps ±1 per env_dir and saturates at 0 and 15 (no wrap).
  - env_period=0: volume held.
- Output: noise = (enabled & ~lfsr[0]) ? volume : 4'd0. Registered, valid one clk after state update.
- Simultaneous events:
  - Trigger has priority over length/envelope/divider events in the same clk.
  - Length and envelope ticks in the same clk are both applied.
- Input changes other than trigger take effect at the next reload. They do not restart counters.
- Trigger while enabled fully restarts the channel, as above.
- rst_n low mid-play returns the block to the reset state immediately.

Test Plan:
- Reset: rst_n=0 with arbitrary inputs -> noise=0; after release with no trigger, noise stays 0.
- Basic noise, envelope and length:
  - Stimulus: L=63, vol=7, dir=0, period=3, s=0, width=0, r=0, length_enable=0; trigger pulse.
  - LFSR steps every 8 clks; noise toggles between 0 and 7 in LFSR sequence (first step from 7FFF: x=0, output bit0 stays 1 → noise 0 until bit0 clears).
  - Volume drops by 1 every 3 clk64 ticks: 7,6,…,0, then holds 0.
  - Channel never disabled.
- Length stop: L=60, length_enable=1, vol=15, period=0 -> exactly 4 clk256 ticks after trigger enabled=0 and noise=0 thereafter.
- Divider: r=2, s=3 -> LFSR step interval 256 clks. r=1, s=14 -> no LFSR steps, noise constant.
- 7-bit mode: width=1 from 7FFF -> lfsr[6:0] sequence period 127 steps. width=0 -> period 32767 steps.
- DAC-off and saturation:
  - vol=0, dir=0, trigger -> noise=0.
  - vol=14, dir=1, period=1 -> volume 15 after one clk64 tick, stays 15.
